// File: rtl/arm7_dump_ctrl.sv
// End-of-run dump engine for arm7_sys: waits for a software halt or a cycle timeout, then
// scans a memory window and the register file and streams initialised entries as records.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | counting cycles, waiting for halt or timeout
// MEM_REQ  | one-cycle memory read request for addr
// MEM_WAIT | read outstanding, address held until ack
// MEM_EMIT | memory record presented, waiting for rec_ready
// MEM_NEXT | end-of-window test, then advance addr
// REG_READ | combinational register read of idx
// REG_EMIT | register record presented, waiting for rec_ready
// REG_NEXT | last-register test, then advance idx
// DONE     | dump complete, sticky until RESET
module arm7_dump_ctrl #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] MEM_BASE   = 16'hA000,
  parameter logic [ADDR_W-1:0] MEM_LAST   = 16'hFFFF,
  parameter int                NUM_REGS   = 16,
  parameter int                REG_IDX_W  = 4,
  parameter int                TIME_LIMIT = 20000,
  parameter int                CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 halt,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic                 mem_rd_ack,
  input  logic [DATA_W-1:0]    mem_rd_data,
  input  logic                 mem_rd_init,
  output logic [REG_IDX_W-1:0] rf_rd_idx,
  input  logic [DATA_W-1:0]    rf_rd_data,
  input  logic                 rf_rd_init,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic                 rec_kind,
  output logic [ADDR_W-1:0]    rec_index,
  output logic [DATA_W-1:0]    rec_data,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic [CNT_W-1:0]     cycle_count
);

  typedef enum logic [3:0] {
    IDLE, MEM_REQ, MEM_WAIT, MEM_EMIT, MEM_NEXT, REG_READ, REG_EMIT, REG_NEXT, DONE
  } state_t;

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]     TMO_CNT  = CNT_W'(TIME_LIMIT - 1);
  localparam bit                   TMO_ON   = (TIME_LIMIT != 0);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [REG_IDX_W-1:0] idx;
  logic                tmo_hit;
  logic                trigger;

  assign tmo_hit = TMO_ON && (cycle_count == TMO_CNT);
  assign trigger = halt || tmo_hit;

  always_ff @(posedge clk) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (trigger) state_nxt = MEM_REQ;
      MEM_REQ:  state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_rd_ack) state_nxt = mem_rd_init ? MEM_EMIT : MEM_NEXT;
      MEM_EMIT: if (rec_ready) state_nxt = MEM_NEXT;
      MEM_NEXT: state_nxt = (addr == MEM_LAST) ? REG_READ : MEM_REQ;
      REG_READ: state_nxt = rf_rd_init ? REG_EMIT : REG_NEXT;
      REG_EMIT: if (rec_ready) state_nxt = REG_NEXT;
      REG_NEXT: state_nxt = (idx == LAST_IDX) ? DONE : REG_READ;
      DONE:     state_nxt = DONE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = 1'b0;
    rec_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE:               busy = 1'b0;
      MEM_REQ:            mem_rd_en = 1'b1;
      MEM_EMIT, REG_EMIT: rec_valid = 1'b1;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_rd_addr = addr;
  assign rf_rd_idx   = idx;

  // The end-of-window compare happens before the increment so a window ending at
  // all-ones never wraps back to address zero.
  always_ff @(posedge clk) begin
    if (RESET) begin
      addr        <= '0;
      idx         <= '0;
      rec_kind    <= 1'b0;
      rec_index   <= '0;
      rec_data    <= '0;
      timed_out   <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            addr      <= MEM_BASE;
            idx       <= '0;
            timed_out <= ~halt;
          end else if (cycle_count != {CNT_W{1'b1}}) begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_rd_ack && mem_rd_init) begin
            rec_kind  <= 1'b0;
            rec_index <= addr;
            rec_data  <= mem_rd_data;
          end
        end
        MEM_NEXT: if (addr != MEM_LAST) addr <= addr + 1'b1;
        REG_READ: begin
          if (rf_rd_init) begin
            rec_kind  <= 1'b1;
            rec_index <= ADDR_W'(idx);
            rec_data  <= rf_rd_data;
          end
        end
        REG_NEXT: if (idx != LAST_IDX) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
